// File: rtl/wb_retire_buffer.sv
// In-order retire buffer for the RV32I write-back stage: queues completed
// instructions, pairs loads with in-order memory responses, retires one write per cycle.
module wb_retire_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int RIDX  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_load_regfile,
    input  logic [RIDX-1:0] in_rd,
    input  logic [2:0]      in_sel,
    input  logic [XLEN-1:0] in_result,
    input  logic [1:0]      in_byte_off,
    input  logic            mem_resp,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            load_regfile,
    output logic [RIDX-1:0] rd,
    output logic [XLEN-1:0] rd_data,
    input  logic [RIDX-1:0] query_rs1,
    input  logic [RIDX-1:0] query_rs2,
    output logic            hazard_rs1,
    output logic            hazard_rs2,
    output logic            resp_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] r_q_wr;
    logic [RIDX-1:0]  r_q_rd  [DEPTH];
    logic [2:0]       r_q_sel [DEPTH];
    logic [XLEN-1:0]  r_q_res [DEPTH];
    logic [1:0]       r_q_off [DEPTH];
    logic [AW-1:0]    r_head, r_tail;
    logic [CW-1:0]    r_count, r_nloads;

    logic [XLEN-1:0]  r_resp [DEPTH];
    logic [AW-1:0]    r_rhead, r_rtail;
    logic [CW-1:0]    r_rcount;

    logic             w_push, w_pop, w_push_load, w_pop_load, w_head_load, w_resp_ok;
    logic [XLEN-1:0]  w_word, w_data;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [1:0]       w_off;

    function automatic logic is_load(input logic [2:0] sel);
        return (sel >= 3'd1) && (sel <= 3'd5);
    endfunction

    assign in_ready    = (r_count != FULL);
    assign w_push      = in_valid && in_ready;
    assign w_push_load = w_push && is_load(in_sel);
    assign w_head_load = is_load(r_q_sel[r_head]);
    assign w_pop       = (r_count != '0) && (!w_head_load || (r_rcount != '0));
    assign w_pop_load  = w_pop && w_head_load;
    // Only accept data that some already-queued load is still waiting for.
    assign w_resp_ok   = mem_resp && (r_rcount < r_nloads) && (r_rcount != FULL);

    always_comb begin
        w_word = r_resp[r_rhead];
        w_off  = r_q_off[r_head];
        w_byte = w_word[{w_off, 3'b000} +: 8];
        w_half = w_off[1] ? w_word[31:16] : w_word[15:0];
        case (r_q_sel[r_head])
            3'd1:    w_data = XLEN'($signed(w_word[31:0]));
            3'd2:    w_data = XLEN'($signed(w_byte));
            3'd3:    w_data = XLEN'(w_byte);
            3'd4:    w_data = XLEN'($signed(w_half));
            3'd5:    w_data = XLEN'(w_half);
            default: w_data = r_q_res[r_head];
        endcase
    end

    always_comb begin
        hazard_rs1 = 1'b0;
        hazard_rs2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && r_q_wr[i] && (r_q_rd[i] != '0)) begin
                if (r_q_rd[i] == query_rs1) hazard_rs1 = 1'b1;
                if (r_q_rd[i] == query_rs2) hazard_rs2 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_rd[r_tail]  <= in_rd;
            r_q_sel[r_tail] <= in_sel;
            r_q_res[r_tail] <= in_result;
            r_q_off[r_tail] <= in_byte_off;
        end
        if (w_resp_ok)
            r_resp[r_rtail] <= mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld         <= '0;
            r_q_wr        <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_nloads      <= '0;
            r_rhead       <= '0;
            r_rtail       <= '0;
            r_rcount      <= '0;
            load_regfile  <= 1'b0;
            rd            <= '0;
            rd_data       <= '0;
            resp_overflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + AW'(1);
            end
            // Push after pop: when the queue is full no push happens, so
            // head and tail never alias on the same edge.
            if (w_push) begin
                r_vld[r_tail]  <= 1'b1;
                r_q_wr[r_tail] <= in_load_regfile;
                r_tail         <= r_tail + AW'(1);
            end
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
            r_nloads <= r_nloads + CW'(w_push_load) - CW'(w_pop_load);

            if (w_resp_ok) r_rtail <= r_rtail + AW'(1);
            if (w_pop_load) r_rhead <= r_rhead + AW'(1);
            r_rcount <= r_rcount + CW'(w_resp_ok) - CW'(w_pop_load);
            if (mem_resp && !w_resp_ok) resp_overflow <= 1'b1;

            load_regfile <= w_pop && r_q_wr[r_head] && (r_q_rd[r_head] != '0);
            if (w_pop) begin
                rd      <= r_q_rd[r_head];
                rd_data <= w_data;
            end
        end
    end
endmodule

// File: tb/tb_wb_retire_buffer.sv
// Directed bench for wb_retire_buffer: one task per scenario, inline checks.
module tb_wb_retire_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_load_regfile;
    logic [4:0]  in_rd;
    logic [2:0]  in_sel;
    logic [31:0] in_result;
    logic [1:0]  in_byte_off;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        load_regfile;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic [4:0]  query_rs1, query_rs2;
    logic        hazard_rs1, hazard_rs2, resp_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    wb_retire_buffer #(.XLEN(32), .DEPTH(4), .RIDX(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_load_regfile(in_load_regfile), .in_rd(in_rd), .in_sel(in_sel),
        .in_result(in_result), .in_byte_off(in_byte_off),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .load_regfile(load_regfile), .rd(rd), .rd_data(rd_data),
        .query_rs1(query_rs1), .query_rs2(query_rs2),
        .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
        .resp_overflow(resp_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic ld, input logic [4:0] r, input logic [2:0] s,
                        input logic [31:0] res, input logic [1:0] off);
        in_valid = 1'b1; in_load_regfile = ld; in_rd = r; in_sel = s;
        in_result = res; in_byte_off = off;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic resp(input logic [31:0] d);
        mem_resp = 1'b1; mem_rdata = d;
        tick();
        mem_resp = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; in_load_regfile = 0; in_rd = 0; in_sel = 0;
        in_result = 0; in_byte_off = 0; mem_resp = 0; mem_rdata = 0;
        query_rs1 = 0; query_rs2 = 0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({load_regfile, rd, rd_data, resp_overflow} !== 39'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", {load_regfile, rd, rd_data, resp_overflow});
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_pass();
        query_rs1 = 5'd5;
        #1;
        n_tests++;
        if (hazard_rs1 !== 1'b0) begin n_fail++; $display("FAIL pass_hz_before: got %b want 0", hazard_rs1); end
        push(1'b1, 5'd5, 3'd0, 32'h1234_5678, 2'd0);
        n_tests++;
        if (hazard_rs1 !== 1'b1 || load_regfile !== 1'b0) begin
            n_fail++; $display("FAIL pass_queued: got hz=%b we=%b want hz=1 we=0", hazard_rs1, load_regfile);
        end
        tick();
        n_tests++;
        if (load_regfile !== 1'b1 || rd !== 5'd5 || rd_data !== 32'h1234_5678 || hazard_rs1 !== 1'b0) begin
            n_fail++; $display("FAIL pass_retire: got we=%b rd=%0d d=%h hz=%b want 1 5 12345678 0",
                               load_regfile, rd, rd_data, hazard_rs1);
        end
        tick();
        n_tests++;
        if (load_regfile !== 1'b0) begin n_fail++; $display("FAIL pass_we_drop: got %b want 0", load_regfile); end
        query_rs1 = 5'd0;
    endtask

    task automatic test_byte_load(input logic [2:0] s, input logic [31:0] exp);
        push(1'b1, 5'd3, s, 32'h0, 2'd2);
        tick(); tick();
        n_tests++;
        if (load_regfile !== 1'b0) begin n_fail++; $display("FAIL byte_wait sel%0d: got we=%b want 0", s, load_regfile); end
        resp(32'h0080_0000);
        n_tests++;
        if (load_regfile !== 1'b0) begin n_fail++; $display("FAIL byte_capture_edge sel%0d: got we=%b want 0", s, load_regfile); end
        tick();
        n_tests++;
        if (load_regfile !== 1'b1 || rd !== 5'd3 || rd_data !== exp) begin
            n_fail++; $display("FAIL byte_retire sel%0d: got we=%b rd=%0d d=%h want 1 3 %h", s, load_regfile, rd, rd_data, exp);
        end
        tick();
    endtask

    task automatic test_half_loads();
        push(1'b1, 5'd6, 3'd4, 32'h0, 2'd2);
        push(1'b1, 5'd7, 3'd5, 32'h0, 2'd0);
        resp(32'h8001_7FFF);
        resp(32'h8001_7FFF);
        n_tests++;
        if (load_regfile !== 1'b1 || rd !== 5'd6 || rd_data !== 32'hFFFF_8001) begin
            n_fail++; $display("FAIL half_lh: got we=%b rd=%0d d=%h want 1 6 ffff8001", load_regfile, rd, rd_data);
        end
        tick();
        n_tests++;
        if (load_regfile !== 1'b1 || rd !== 5'd7 || rd_data !== 32'h0000_7FFF) begin
            n_fail++; $display("FAIL half_lhu: got we=%b rd=%0d d=%h want 1 7 00007fff", load_regfile, rd, rd_data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  exp_rd [4];
        logic [31:0] exp_d  [4];
        exp_rd = '{5'd1, 5'd2, 5'd3, 5'd4};
        exp_d  = '{32'hDEAD_BEEF, 32'h22, 32'h33, 32'h44};
        push(1'b1, 5'd1, 3'd1, 32'h0, 2'd3);
        push(1'b1, 5'd2, 3'd0, 32'h22, 2'd0);
        push(1'b1, 5'd3, 3'd6, 32'h33, 2'd0);
        push(1'b1, 5'd4, 3'd0, 32'h44, 2'd0);
        query_rs2 = 5'd4;
        #1;
        n_tests++;
        if (in_ready !== 1'b0 || load_regfile !== 1'b0 || hazard_rs2 !== 1'b1) begin
            n_fail++; $display("FAIL full_stall: got rdy=%b we=%b hz2=%b want 0 0 1", in_ready, load_regfile, hazard_rs2);
        end
        push(1'b1, 5'd9, 3'd0, 32'h99, 2'd0);
        n_tests++;
        if (in_ready !== 1'b0 || load_regfile !== 1'b0) begin
            n_fail++; $display("FAIL full_reject: got rdy=%b we=%b want 0 0", in_ready, load_regfile);
        end
        resp(32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (load_regfile !== 1'b1 || rd !== exp_rd[i] || rd_data !== exp_d[i] || in_ready !== 1'b1) begin
                n_fail++; $display("FAIL drain%0d: got we=%b rd=%0d d=%h rdy=%b want 1 %0d %h 1",
                                   i, load_regfile, rd, rd_data, in_ready, exp_rd[i], exp_d[i]);
            end
        end
        tick();
        n_tests++;
        if (load_regfile !== 1'b0 || hazard_rs2 !== 1'b0) begin
            n_fail++; $display("FAIL drain_end: got we=%b hz2=%b want 0 0", load_regfile, hazard_rs2);
        end
        query_rs2 = 5'd0;
    endtask

    task automatic test_rd0_overflow();
        push(1'b1, 5'd0, 3'd0, 32'h55, 2'd0);
        tick();
        n_tests++;
        if (load_regfile !== 1'b0 || rd !== 5'd0 || rd_data !== 32'h55) begin
            n_fail++; $display("FAIL rd0_write: got we=%b rd=%0d d=%h want 0 0 55", load_regfile, rd, rd_data);
        end
        n_tests++;
        if (resp_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got %b want 0", resp_overflow); end
        resp(32'hABCD_0000);
        n_tests++;
        if (resp_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", resp_overflow); end
        tick(); tick();
        n_tests++;
        if (resp_overflow !== 1'b1 || load_regfile !== 1'b0) begin
            n_fail++; $display("FAIL ovf_sticky: got ovf=%b we=%b want 1 0", resp_overflow, load_regfile);
        end
    endtask

    task automatic test_async_reset();
        push(1'b1, 5'd8, 3'd1, 32'h0, 2'd0);
        push(1'b1, 5'd9, 3'd1, 32'h0, 2'd0);
        resp(32'h0000_0011);
        query_rs1 = 5'd8; query_rs2 = 5'd9;
        rst = 1'b1;
        #2;
        n_tests++;
        if ({load_regfile, rd, rd_data, resp_overflow} !== 39'd0 || hazard_rs1 !== 1'b0 || hazard_rs2 !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got we=%b rd=%0d d=%h ovf=%b hz=%b%b want all 0",
                               load_regfile, rd, rd_data, resp_overflow, hazard_rs1, hazard_rs2);
        end
        rst = 1'b0;
        tick(); tick(); tick();
        n_tests++;
        if (load_regfile !== 1'b0 || in_ready !== 1'b1 || resp_overflow !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: got we=%b rdy=%b ovf=%b want 0 1 0", load_regfile, in_ready, resp_overflow);
        end
        resp(32'h0000_0022);
        tick();
        n_tests++;
        if (resp_overflow !== 1'b1 || load_regfile !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_ovf: got ovf=%b we=%b want 1 0", resp_overflow, load_regfile);
        end
        query_rs1 = 5'd0; query_rs2 = 5'd0;
    endtask

    initial begin
        test_reset();
        test_pass();
        test_byte_load(3'd2, 32'hFFFF_FF80);
        test_byte_load(3'd3, 32'h0000_0080);
        test_half_loads();
        test_back_to_back();
        test_rd0_overflow();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
